// File: rtl/instr_encoder_loader.sv
// RV32I field-bundle encoder feeding a linear imem loader. It validates each bundle, packs it into
// a 32-bit word, and writes the words to consecutive addresses starting at BASE_ADDR.
module instr_encoder_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int BASE_ADDR  = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            fmt,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic [4:0]            rd,
  input  logic [4:0]            rs1,
  input  logic [4:0]            rs2,
  input  logic [31:0]           imm,
  output logic                  imem_we,
  input  logic                  imem_ready,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  err_valid,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full
);
  localparam logic [ADDR_WIDTH:0]   DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH-1:0] BASE  = ADDR_WIDTH'(BASE_ADDR);

  logic                  we_q, we_d;
  logic [31:0]           wdata_q, wdata_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  err_valid_q, err_valid_d;
  logic [1:0]            err_code_q, err_code_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;

  logic        last_slot, accept, done;
  logic [31:0] enc_word;
  logic [1:0]  chk_code;
  logic        fit12, fit13, fit21;

  // A pending write into the final slot blocks accepts, so no bundle is taken that has no slot.
  assign full      = (count_q == DEPTH);
  assign last_slot = we_q && (count_q == DEPTH - 1'b1);
  assign in_ready  = !full && !flush && (!we_q || imem_ready) && !last_slot;
  assign accept    = in_valid && in_ready;
  assign done      = we_q && imem_ready;

  // Signed range checks: every bit above the sign bit must equal the sign bit.
  assign fit12 = (&imm[31:11]) || !(|imm[31:11]);
  assign fit13 = (&imm[31:12]) || !(|imm[31:12]);
  assign fit21 = (&imm[31:20]) || !(|imm[31:20]);

  always_comb begin
    enc_word = '0;
    chk_code = 2'b00;
    case (fmt)
      3'd0: enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
      3'd1: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        if (!fit12) chk_code = 2'b01;
      end
      3'd2: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        if (!fit12) chk_code = 2'b01;
      end
      3'd3: begin
        enc_word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
        if (imm[0])      chk_code = 2'b10;
        else if (!fit13) chk_code = 2'b01;
      end
      3'd4: begin
        enc_word = {imm[31:12], rd, opcode};
        if (|imm[11:0]) chk_code = 2'b01;
      end
      3'd5: begin
        enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
        if (imm[0])      chk_code = 2'b10;
        else if (!fit21) chk_code = 2'b01;
      end
      default: chk_code = 2'b11;
    endcase
  end

  always_comb begin
    we_d        = we_q;
    wdata_d     = wdata_q;
    addr_d      = addr_q;
    count_d     = count_q;
    err_valid_d = 1'b0;
    err_code_d  = err_code_q;
    if (flush) begin
      we_d    = 1'b0;
      addr_d  = BASE;
      count_d = '0;
    end else begin
      if (done) begin
        we_d    = 1'b0;
        count_d = count_q + 1'b1;
        // The pointer stays on the final word rather than wrapping.
        if (count_q != DEPTH - 1'b1) addr_d = addr_q + 1'b1;
      end
      if (accept) begin
        if (chk_code != 2'b00) begin
          err_valid_d = 1'b1;
          err_code_d  = chk_code;
        end else begin
          we_d    = 1'b1;
          wdata_d = enc_word;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q        <= 1'b0;
      wdata_q     <= '0;
      addr_q      <= BASE;
      err_valid_q <= 1'b0;
      err_code_q  <= 2'b00;
      count_q     <= '0;
    end else begin
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      addr_q      <= addr_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
      count_q     <= count_d;
    end
  end

  assign imem_we    = we_q;
  assign imem_wdata = wdata_q;
  assign imem_addr  = addr_q;
  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign count      = count_q;
endmodule
